// File: rtl/nurn_core_pkg.sv
`default_nettype none
// nurn_core_pkg: shared FSM encoding and Q8.8 fixed-point constants for the LIF neuron core.
package nurn_core_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      FIRE = 2'd2,
      DONE = 2'd3
   } nurn_state_t;

   localparam int DSIZE_INT  = 8;
   localparam int DSIZE_FRAC = 8;
   localparam int Q_DSIZE    = DSIZE_INT + DSIZE_FRAC;

   localparam logic signed [Q_DSIZE-1:0] Q_SAT_MAX = 16'sh7FFF;
   localparam logic signed [Q_DSIZE-1:0] Q_SAT_MIN = 16'sh8000;

endpackage
`default_nettype wire

// File: rtl/aer_fifo.sv
`default_nettype none
// aer_fifo: first-word fall-through spike packet queue with sticky overflow flag.
module aer_fifo #(
   parameter int AER_BIT_WIDTH = 32,
   parameter int FIFO_DEPTH    = 4
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [AER_BIT_WIDTH-1:0] push_data,
   input  logic                     rdy,
   output logic                     vld,
   output logic [AER_BIT_WIDTH-1:0] head,
   output logic                     ovf
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [AER_BIT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW:0]              wr_ptr;
   logic [PW:0]              rd_ptr;
   logic                     empty;
   logic                     full;
   logic                     pop;
   logic                     accept;
   logic                     drop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign pop    = !empty && rdy;
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   assign vld  = !empty;
   assign head = empty ? '0 : mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         if (drop)   ovf    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/lif_nurn_core.sv
`default_nettype none
// lif_nurn_core: time-multiplexed leaky integrate-and-fire neuron core with AER spike output queue.
// Build macro NURN_LEAK_EN subtracts leak_i from each neuron potential once per timestep.
module lif_nurn_core
   import nurn_core_pkg::*;
#(
   parameter int NUM_NURNS          = 4,
   parameter int NUM_AXONS          = 4,
   parameter int NURN_CNT_BIT_WIDTH = 2,
   parameter int AXON_CNT_BIT_WIDTH = 2,
   parameter int DSIZE              = 16,
   parameter int AER_BIT_WIDTH      = 32,
   parameter int FIFO_DEPTH         = 4
)(
   input  logic                                         clk_i,
   input  logic                                         rst_n_i,
   input  logic                                         start_i,
   input  logic [NUM_AXONS-1:0]                         inSpike_i,
   input  logic                                         wgtWrEn_i,
   input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wgtWrAddr_i,
   input  logic signed [DSIZE-1:0]                      wgtWrData_i,
   input  logic signed [DSIZE-1:0]                      Th_i,
   input  logic signed [DSIZE-1:0]                      RstPot_i,
   input  logic signed [DSIZE-1:0]                      leak_i,
   output logic                                         busy_o,
   output logic                                         done_o,
   output logic                                         spikeVld_o,
   output logic [AER_BIT_WIDTH-1:0]                     spikeAER_o,
   input  logic                                         spikeRdy_i,
   output logic                                         ovf_o
);

   localparam int WA_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
   localparam logic signed [DSIZE-1:0] SAT_MAX = {1'b0, {(DSIZE-1){1'b1}}};
   localparam logic signed [DSIZE-1:0] SAT_MIN = {1'b1, {(DSIZE-1){1'b0}}};

   nurn_state_t                   state;
   nurn_state_t                   state_nxt;
   logic [NURN_CNT_BIT_WIDTH-1:0] nurn_cnt;
   logic [AXON_CNT_BIT_WIDTH-1:0] axon_cnt;
   logic [NUM_AXONS-1:0]          spk_lat;
   logic signed [DSIZE-1:0]       acc;
   logic signed [DSIZE-1:0]       acc_base;
   logic signed [DSIZE-1:0]       acc_next;
   logic signed [DSIZE-1:0]       pot_entry;
   logic signed [DSIZE-1:0]       wgt [NUM_NURNS][NUM_AXONS];
   logic signed [DSIZE-1:0]       pot [NUM_NURNS];
   logic                          last_axon;
   logic                          last_nurn;
   logic                          fire_now;
   logic                          push;

   function automatic logic signed [DSIZE-1:0] sat_arith(
      input logic signed [DSIZE-1:0] x,
      input logic signed [DSIZE-1:0] y,
      input logic                    sub
   );
      logic signed [DSIZE:0] s;
      s = sub ? ({x[DSIZE-1], x} - {y[DSIZE-1], y})
              : ({x[DSIZE-1], x} + {y[DSIZE-1], y});
      if (s[DSIZE] != s[DSIZE-1]) return s[DSIZE] ? SAT_MIN : SAT_MAX;
      return s[DSIZE-1:0];
   endfunction

`ifdef NURN_LEAK_EN
   assign pot_entry = sat_arith(pot[nurn_cnt], leak_i, 1'b1);
`else
   logic unused_leak;
   assign unused_leak = ^leak_i;
   assign pot_entry   = pot[nurn_cnt];
`endif

   assign last_axon = (axon_cnt == AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1));
   assign last_nurn = (nurn_cnt == NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1));

   // The first axon of each neuron starts from its stored potential, not the running sum.
   assign acc_base = (axon_cnt == '0) ? pot_entry : acc;
   assign acc_next = spk_lat[axon_cnt] ? sat_arith(acc_base, wgt[nurn_cnt][axon_cnt], 1'b0)
                                       : acc_base;
   assign fire_now = ($signed(acc) >= $signed(Th_i));
   assign push     = (state == FIRE) && fire_now;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_o    = 1'b1;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) state_nxt = ACC;
         end
         ACC:  if (last_axon) state_nxt = FIRE;
         FIRE: state_nxt = last_nurn ? DONE : ACC;
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         nurn_cnt <= '0;
         axon_cnt <= '0;
         spk_lat  <= '0;
         acc      <= '0;
         for (int i = 0; i < NUM_NURNS; i++) pot[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  spk_lat  <= inSpike_i;
                  nurn_cnt <= '0;
                  axon_cnt <= '0;
               end
            end
            ACC: begin
               acc      <= acc_next;
               axon_cnt <= last_axon ? '0 : axon_cnt + 1'b1;
            end
            FIRE: begin
               pot[nurn_cnt] <= fire_now ? RstPot_i : acc;
               if (!last_nurn) nurn_cnt <= nurn_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Weights are configuration storage only; they are never cleared by reset.
   always_ff @(posedge clk_i) begin
      if (wgtWrEn_i && (state == IDLE))
         wgt[wgtWrAddr_i[WA_W-1 -: NURN_CNT_BIT_WIDTH]][wgtWrAddr_i[AXON_CNT_BIT_WIDTH-1:0]] <= wgtWrData_i;
   end

   aer_fifo #(
      .AER_BIT_WIDTH (AER_BIT_WIDTH),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) u_aer_fifo (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .push      (push),
      .push_data (AER_BIT_WIDTH'(nurn_cnt)),
      .rdy       (spikeRdy_i),
      .vld       (spikeVld_o),
      .head      (spikeAER_o),
      .ovf       (ovf_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_lif_nurn_core.sv
`default_nettype none
// tb_lif_nurn_core: directed stimulus with a per-cycle timestep/queue model and literal spot checks.
`timescale 1ns/1ps
module tb_lif_nurn_core;

   localparam int NN    = 4;
   localparam int NA    = 4;
   localparam int NW    = 2;
   localparam int AW    = 2;
   localparam int DS    = 16;
   localparam int AERW  = 32;
   localparam int DEPTH = 4;
   localparam int LAT   = NN * (NA + 1) + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [NA-1:0]   in_spike = '0;
   logic            wen = 1'b0;
   logic [NW+AW-1:0] waddr = '0;
   logic [DS-1:0]   wdata = '0;
   logic [DS-1:0]   th = '0;
   logic [DS-1:0]   rstpot = '0;
   logic [DS-1:0]   leak = '0;
   logic            rdy = 1'b0;
   logic            busy;
   logic            done;
   logic            vld;
   logic            ovf;
   logic [AERW-1:0] aer;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lif_nurn_core dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .start_i     (start),
      .inSpike_i   (in_spike),
      .wgtWrEn_i   (wen),
      .wgtWrAddr_i (waddr),
      .wgtWrData_i (wdata),
      .Th_i        (th),
      .RstPot_i    (rstpot),
      .leak_i      (leak),
      .busy_o      (busy),
      .done_o      (done),
      .spikeVld_o  (vld),
      .spikeAER_o  (aer),
      .spikeRdy_i  (rdy),
      .ovf_o       (ovf)
   );

   // ---------------- behavioural model ----------------
   int m_w [NN][NA];
   int m_pot [NN];
   bit m_fire [NN];
   int m_phase = 0;
   int m_q [$];
   bit m_ovf = 1'b0;
   int m_acc;
   int m_sz;
   bit m_pop;
   bit m_push;
   int m_pval;

   function automatic int sat16(input int x);
      if (x > 32767)  return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // Whole timestep is resolved at the start edge; spikes are released at each neuron's FIRE slot.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_q.delete();
         m_ovf = 1'b0;
         for (int n = 0; n < NN; n++) m_pot[n] = 0;
      end else begin
         m_sz   = m_q.size();
         m_pop  = (m_sz > 0) && rdy;
         m_push = 1'b0;
         m_pval = 0;
         for (int n = 0; n < NN; n++)
            if (m_phase == (n + 1) * (NA + 1) && m_fire[n]) begin
               m_push = 1'b1;
               m_pval = n;
            end
         if (m_pop) void'(m_q.pop_front());
         if (m_push) begin
            if (m_sz < DEPTH || m_pop) m_q.push_back(m_pval);
            else                       m_ovf = 1'b1;
         end
         if (m_phase == LAT)    m_phase = 0;
         else if (m_phase > 0)  m_phase++;
         else begin
            if (wen) m_w[int'(waddr[NW+AW-1:AW])][int'(waddr[AW-1:0])] = int'($signed(wdata));
            if (start) begin
               for (int n = 0; n < NN; n++) begin
                  m_acc = m_pot[n];
`ifdef NURN_LEAK_EN
                  m_acc = sat16(m_acc - int'($signed(leak)));
`endif
                  for (int a = 0; a < NA; a++)
                     if (in_spike[a]) m_acc = sat16(m_acc + m_w[n][a]);
                  m_fire[n] = (m_acc >= int'($signed(th)));
                  m_pot[n]  = m_fire[n] ? int'($signed(rstpot)) : m_acc;
               end
               m_phase = 1;
            end
         end
      end
   end

   logic [AERW-1:0] e_aer;
   always @(negedge clk) begin
      e_aer = (m_q.size() > 0) ? AERW'(m_q[0]) : '0;
      vectors++;
      if (busy !== (m_phase != 0) || done !== (m_phase == LAT) || vld !== (m_q.size() > 0) ||
          ovf !== m_ovf || (m_q.size() > 0 && aer !== e_aer)) begin
         miscompares++;
         $display("FAIL model t=%0t busy=%b/%b done=%b/%b vld=%b/%b aer=%0h/%0h ovf=%b/%b",
                  $time, busy, (m_phase != 0), done, (m_phase == LAT), vld, (m_q.size() > 0),
                  aer, e_aer, ovf, m_ovf);
      end
   end

   logic [AERW-1:0] log_q [$];
   always @(negedge clk) if (rst_n && vld && rdy) log_q.push_back(aer);

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; wen = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      log_q.delete();
   endtask

   task automatic write_one(input int n, input int a, input logic [DS-1:0] val);
      wen = 1'b1; waddr = (NW+AW)'(n * NA + a); wdata = val;
      step();
      wen = 1'b0;
   endtask

   task automatic write_all(input logic [DS-1:0] val);
      for (int i = 0; i < NN * NA; i++) write_one(i / NA, i % NA, val);
   endtask

   task automatic run_ts(input logic [NA-1:0] spikes, output int lat);
      in_spike = spikes; start = 1'b1;
      step();
      start = 1'b0;
      lat = 1;
      while (!done && lat < 60) begin
         step();
         lat++;
      end
      step();
   endtask

   function automatic logic [31:0] log_at(input int i);
      return (i < log_q.size()) ? log_q[i] : 32'hFFFF_FFFF;
   endfunction

   int lat;
   int done_cnt;
   int done_at;
   int first_ts;

   initial begin
      // reset state
      do_reset();
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_vld",  {31'd0, vld},  32'd0);
      check("reset_ovf",  {31'd0, ovf},  32'd0);

      // integrate over two timesteps, fire on the second
      write_all(16'h0000);
      write_one(0, 0, 16'h0100);
      th = 16'h0200; rstpot = 16'h0000; leak = 16'h0000; rdy = 1'b1;
      run_ts(4'b0001, lat);
      check("latency", lat, 32'd21);
      check("ts1_no_spike", log_q.size(), 32'd0);
      run_ts(4'b0001, lat);
      check("ts2_one_spike", log_q.size(), 32'd1);
      check("ts2_pkt0", log_at(0), 32'd0);
      check("pot0_reset", {16'h0, dut.pot[0]}, 32'd0);

      // saturation, all neurons fire in order
      do_reset();
      write_all(16'h7F00);
      th = 16'h7F00; rdy = 1'b1;
      run_ts(4'b1111, lat);
      check("sat_acc", {16'h0, dut.acc}, 32'h0000_7FFF);
      check("sat_count", log_q.size(), 32'd4);
      for (int i = 0; i < 4; i++) check("sat_order", log_at(i), i);

      // back-pressure overflow
      do_reset();
      write_all(16'h0000);
      th = 16'h8000; rdy = 1'b0;
      run_ts(4'b0000, lat);
      run_ts(4'b0000, lat);
      check("ovf_set", {31'd0, ovf}, 32'd1);
      check("held_vld", {31'd0, vld}, 32'd1);
      rdy = 1'b1;
      repeat (6) step();
      check("held_count", log_q.size(), 32'd4);
      for (int i = 0; i < 4; i++) check("held_order", log_at(i), i);
      check("ovf_sticky", {31'd0, ovf}, 32'd1);

      // start while busy is ignored
      do_reset();
      th = 16'h7FFF; rdy = 1'b1;
      in_spike = 4'hF; start = 1'b1;
      step();
      start = 1'b0;
      done_cnt = 0; done_at = 0;
      for (int c = 1; c <= 30; c++) begin
         if (done) begin done_cnt++; done_at = c; end
         start = (c == 5);
         step();
      end
      start = 1'b0;
      check("restart_done_cnt", done_cnt, 32'd1);
      check("restart_done_at", done_at, 32'd21);

      // asynchronous reset mid-timestep
      do_reset();
      th = 16'h8000; rdy = 1'b0;
      run_ts(4'b0000, lat);
      in_spike = 4'b0000; start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      check("pre_rst_ovf", {31'd0, ovf}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_vld",  {31'd0, vld},  32'd0);
      check("rst_aer",  aer, 32'd0);
      check("rst_ovf",  {31'd0, ovf},  32'd0);
      step(); step();
      rst_n = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         if (done) done_cnt++;
         step();
      end
      check("rst_no_done", done_cnt, 32'd0);

      // leak delays the first spike
      do_reset();
      write_all(16'h0000);
      write_one(0, 0, 16'h0100);
      th = 16'h0180; rstpot = 16'h0000; leak = 16'h0080; rdy = 1'b1;
      first_ts = 0;
      for (int t = 1; t <= 3; t++) begin
         run_ts(4'b0001, lat);
         if (first_ts == 0 && log_q.size() > 0) first_ts = t;
      end
`ifdef NURN_LEAK_EN
      check("leak_first_ts", first_ts, 32'd3);
`else
      check("leak_first_ts", first_ts, 32'd2);
`endif
      check("leak_pkt", log_at(0), 32'd0);
      leak = 16'h0000;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
